// File: rtl/dac_wave_sequencer.sv
// ============================================================================
// Module      : dac_wave_sequencer
// Description : Plays an index range of a host-written waveform table into
//               the DAC sample FIFO, adding a saturating signed offset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_wave_sequencer #(
    parameter int TBL_AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tbl_we,
    input  logic [TBL_AW-1:0] tbl_waddr,
    input  logic [9:0]        tbl_wdata,
    input  logic              start,
    input  logic              stop,
    input  logic [TBL_AW-1:0] start_idx,
    input  logic [TBL_AW-1:0] end_idx,
    input  logic [7:0]        reps,
    input  logic [10:0]       offset,
    input  logic              dac_low,
    output logic [9:0]        dac_data,
    output logic              dac_wr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [TBL_AW-1:0] cur_idx
);

    localparam int c_DEPTH = 2 ** TBL_AW;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_FETCH = 2'd1,
        c_PUSH  = 2'd2,
        c_GAP   = 2'd3
    } state_t;

    state_t            r_state;
    logic [9:0]        r_table [0:c_DEPTH-1];
    logic [9:0]        r_sample;
    logic [TBL_AW-1:0] r_start_idx;
    logic [TBL_AW-1:0] r_end_idx;
    logic [10:0]       r_offset;
    logic [7:0]        r_rep_cnt;
    logic [TBL_AW-1:0] r_cur_idx;
    logic              r_done;
    logic              r_err;

    logic [11:0]       w_sum;
    logic [9:0]        w_sat;

    // Table storage has no reset; the fetch read sees the pre-write value
    // when a host write lands on the same edge.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            r_table[tbl_waddr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_sample    <= '0;
            r_start_idx <= '0;
            r_end_idx   <= '0;
            r_offset    <= '0;
            r_rep_cnt   <= '0;
            r_cur_idx   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (stop && (r_state != c_IDLE)) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        // stop outranks a coincident start
                        if (start && !stop) begin
                            if (start_idx <= end_idx) begin
                                r_start_idx <= start_idx;
                                r_end_idx   <= end_idx;
                                r_offset    <= offset;
                                r_rep_cnt   <= reps;
                                r_cur_idx   <= start_idx;
                                r_state     <= c_FETCH;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    c_FETCH: begin
                        if (dac_low) begin
                            r_sample <= r_table[r_cur_idx];
                            r_state  <= c_PUSH;
                        end
                    end
                    c_PUSH: begin
                        if (r_cur_idx != r_end_idx) begin
                            r_cur_idx <= r_cur_idx + 1'b1;
                            r_state   <= c_GAP;
                        end else if (r_rep_cnt == 8'd0) begin
                            r_cur_idx <= r_start_idx;
                            r_state   <= c_GAP;
                        end else if (r_rep_cnt == 8'd1) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_rep_cnt <= r_rep_cnt - 8'd1;
                            r_cur_idx <= r_start_idx;
                            r_state   <= c_GAP;
                        end
                    end
                    c_GAP: begin
                        r_state <= c_FETCH;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    // 12-bit two's-complement sum; bit 11 flags negative, bit 10 overflow.
    assign w_sum = {2'b00, r_sample} + {r_offset[10], r_offset};

    always_comb begin
        w_sat = w_sum[9:0];
        if (w_sum[11]) begin
            w_sat = 10'd0;
        end else if (w_sum[10]) begin
            w_sat = 10'h3FF;
        end
    end

    assign dac_data = w_sat;
    assign dac_wr   = (r_state == c_PUSH);
    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign cur_idx  = r_cur_idx;

endmodule

`default_nettype wire

// File: tb/tb_dac_wave_sequencer.sv
// ============================================================================
// Module      : tb_dac_wave_sequencer
// Description : Scoreboard bench for dac_wave_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_wave_sequencer;

    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic          tbl_we;
    logic [AW-1:0] tbl_waddr;
    logic [9:0]    tbl_wdata;
    logic          start;
    logic          stop;
    logic [AW-1:0] start_idx;
    logic [AW-1:0] end_idx;
    logic [7:0]    reps;
    logic [10:0]   offset;
    logic          dac_low;
    logic [9:0]    dac_data;
    logic          dac_wr;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] cur_idx;

    dac_wave_sequencer #(.TBL_AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tbl_we    (tbl_we),
        .tbl_waddr (tbl_waddr),
        .tbl_wdata (tbl_wdata),
        .start     (start),
        .stop      (stop),
        .start_idx (start_idx),
        .end_idx   (end_idx),
        .reps      (reps),
        .offset    (offset),
        .dac_low   (dac_low),
        .dac_data  (dac_data),
        .dac_wr    (dac_wr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cur_idx   (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int shadow [0:63];
    int exp_q [$];
    int wr_times [$];
    int wr_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    int done_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: every write is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dac_wr) begin
                wr_times.push_back(cyc);
                wr_count++;
                if (exp_q.size() == 0)
                    check("wr_expected", 0, 1);
                else
                    check("dac_data", int'(dac_data), exp_q.pop_front());
            end
            if (done) begin
                done_count++;
                done_cyc  = cyc;
                done_busy = int'(busy);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int sat(input int s, input int off);
        int v;
        v = s + off;
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input int addr, input int data);
        tbl_we    = 1'b1;
        tbl_waddr = addr[AW-1:0];
        tbl_wdata = data[9:0];
        tick();
        tbl_we    = 1'b0;
        shadow[addr] = data;
    endtask

    // Pushes the expected stream (optionally) and pulses start.
    task automatic play(input int s, input int e, input int r, input int off, input bit push);
        if (push) begin
            for (int p = 0; p < r; p++)
                for (int i = s; i <= e; i++)
                    exp_q.push_back(sat(shadow[i], off));
        end
        start_idx = s[AW-1:0];
        end_idx   = e[AW-1:0];
        reps      = r[7:0];
        offset    = off[10:0];
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int b;
        b = 200;
        while (done_count == d0 && b > 0) begin
            tick();
            b--;
        end
        check({tag, "_done_seen"}, done_count - d0, 1);
        check({tag, "_busy_at_done"}, done_busy, 0);
        check({tag, "_done_lat"}, done_cyc - wr_times[$], 1);
        check({tag, "_q_empty"}, exp_q.size(), 0);
        tick();
        tick();
        check({tag, "_done_once"}, done_count - d0, 1);
    endtask

    initial begin
        int k, d0, w0, cs, b, lat;
        rst_n = 1'b0; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
        start = 1'b0; stop = 1'b0; start_idx = '0; end_idx = '0;
        reps = '0; offset = '0; dac_low = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = 0;
        repeat (3) tick();
        check("rst_dac_data", int'(dac_data), 0);
        check("rst_dac_wr", int'(dac_wr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_cur_idx", int'(cur_idx), 0);
        rst_n = 1'b1;
        tick();

        // Single pass
        tbl_write(0, 10); tbl_write(1, 20); tbl_write(2, 30); tbl_write(3, 40);
        k = wr_times.size(); d0 = done_count; cs = cyc;
        play(0, 3, 1, 0, 1);
        check("t1_busy", int'(busy), 1);
        wait_done("t1", d0);
        check("t1_first_lat", wr_times[k] - cs, 2);
        for (int i = 1; i < 4; i++)
            check("t1_gap", wr_times[k+i] - wr_times[k+i-1], 3);

        // Repeat and wrap at the top of the table
        tbl_write(62, 111); tbl_write(63, 222);
        k = wr_times.size(); d0 = done_count;
        play(62, 63, 3, 0, 1);
        check("t2_cur_idx", int'(cur_idx), 62);
        wait_done("t2", d0);
        check("t2_writes", wr_times.size() - k, 6);

        // Saturation
        tbl_write(5, 1000); d0 = done_count; play(5, 5, 1, 100, 1);  wait_done("sat_hi", d0);
        tbl_write(5, 50);   d0 = done_count; play(5, 5, 1, -100, 1); wait_done("sat_lo", d0);
        tbl_write(5, 500);  d0 = done_count; play(5, 5, 1, -20, 1);  wait_done("sat_mid", d0);

        // Flow control with infinite repetition
        dac_low = 1'b0; w0 = wr_count; d0 = done_count;
        for (int i = 0; i < 10; i++) exp_q.push_back(shadow[i % 4]);
        play(0, 3, 0, 0, 0);
        repeat (20) tick();
        check("fc_no_wr_low", wr_count - w0, 0);
        check("fc_busy", int'(busy), 1);
        k = wr_times.size(); cs = cyc;
        dac_low = 1'b1;
        b = 10;
        while (wr_count == w0 && b > 0) begin tick(); b--; end
        lat = (wr_times.size() > k) ? wr_times[k] - cs : 99;
        check("fc_resume_le2", int'(lat <= 2), 1);
        b = 100;
        while (wr_count - w0 < 10 && b > 0) begin tick(); b--; end
        check("fc_writes", wr_count - w0, 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("fc_stop_idle", int'(busy), 0);
        repeat (4) tick();
        check("fc_no_done", done_count - d0, 0);
        check("fc_no_more_wr", wr_count - w0, 10);
        check("fc_q_empty", exp_q.size(), 0);

        // Rejected start
        start_idx = 6'd9; end_idx = 6'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", int'(err), 1);
        check("err_busy", int'(busy), 0);
        tick();
        check("err_once", int'(err), 0);

        // start and stop together
        w0 = wr_count;
        start_idx = 6'd0; end_idx = 6'd3; reps = 8'd1; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", int'(busy), 0);
        check("ss_err", int'(err), 0);
        repeat (5) tick();
        check("ss_no_wr", wr_count - w0, 0);

        // start while busy is ignored; config changes after start have no effect
        d0 = done_count; k = wr_times.size();
        play(0, 3, 1, 0, 1);
        tick(); tick();
        start_idx = 6'd62; end_idx = 6'd63; reps = 8'd2; offset = 11'd500; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_err", int'(err), 0);
        wait_done("busy_start", d0);
        check("busy_start_writes", wr_times.size() - k, 4);

        // Concurrent table write on the fetch cycle
        tbl_write(7, 100);
        d0 = done_count;
        exp_q.push_back(100);
        exp_q.push_back(300);
        play(7, 7, 2, 0, 0);
        tbl_we = 1'b1; tbl_waddr = 6'd7; tbl_wdata = 10'd300;
        tick();
        tbl_we = 1'b0; shadow[7] = 300;
        wait_done("cw", d0);

        // Asynchronous reset in the middle of a PUSH
        w0 = wr_count;
        exp_q.push_back(shadow[0]);
        play(0, 3, 1, 0, 0);
        b = 10;
        do begin
            @(negedge clk);
            b--;
        end while (!dac_wr && b > 0);
        check("rp_saw_push", int'(dac_wr), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rp_wr_drop", int'(dac_wr), 0);
        check("rp_busy_drop", int'(busy), 0);
        check("rp_cur_idx", int'(cur_idx), 0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("rp_writes", wr_count - w0, 1);
        check("rp_idle", int'(busy), 0);
        check("rp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
